// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the two-master DDR burst arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FINISH} state_t;
  typedef logic [0:0] mid_t;

  localparam int DEF_BURST_LEN = 32;
  localparam int DEF_TAG_DEPTH = 4;

  function automatic logic [1:0] id2mask(input mid_t id);
    return 2'b01 << id;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// In-order record of which master issued each outstanding read burst.
// Zero-latency head; caller must not push when full nor pop when empty.
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  mid_t push_dat_i,
  input  logic pop_i,
  output mid_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  mid_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin whole-burst arbiter of two masters onto one DDR wr/rd port; grant one cycle
// after pick, beats combinational on !busy; read returns steered by the in-order tag FIFO.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rst_n,
  input  logic [1:0]            m_req,
  input  logic [1:0]            m_wr,
  input  logic [2*ADDR_W-1:0]   m_addr,
  output logic [1:0]            m_grant,
  output logic [1:0]            m_done,
  input  logic [2*DATA_W-1:0]   m_wdata,
  output logic [1:0]            m_wdata_ack,
  output logic [DATA_W-1:0]     m_rd_data,
  output logic [1:0]            m_rd_valid,
  input  logic                  ddr_wr_busy,
  output logic                  ddr_wr_en,
  output logic [ADDR_W-1:0]     ddr_wr_addr,
  output logic [DATA_W-1:0]     ddr_wr_data,
  output logic [DATA_W/8-1:0]   ddr_wr_mask,
  input  logic                  ddr_rd_busy,
  output logic                  ddr_rd_en,
  output logic [ADDR_W-1:0]     ddr_rd_addr,
  input  logic [DATA_W-1:0]     ddr_rd_data,
  input  logic                  ddr_rd_valid,
  output logic                  err_o
);

  localparam int             BW   = $clog2(BURST_LEN);
  localparam logic [BW-1:0]  LAST = BW'(BURST_LEN - 1);

  state_t            state_q, state_d;
  mid_t              id_q, id_d, rr_last_q, rr_last_d, pick_id;
  logic [ADDR_W-1:0] base_q, base_d, beat_addr;
  logic [BW-1:0]     beat_q, beat_d, ret_cnt_q, ret_cnt_d;
  logic [1:0]        grant_q, grant_d, eligible;
  logic              err_q, err_d;
  logic              tag_push, tag_pop, tag_full, tag_empty;
  mid_t              tag_head;

  ddr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk        (ddr_clk),
    .rst_n      (ddr_rst_n),
    .push_i     (tag_push),
    .push_dat_i (pick_id),
    .pop_i      (tag_pop),
    .head_o     (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  // A read is only eligible while the tag FIFO can record it; writes never wait on reads.
  assign eligible  = m_req & (m_wr | {2{~tag_full}});
  assign pick_id   = (eligible == 2'b11) ? ~rr_last_q : mid_t'(eligible[1]);
  assign beat_addr = base_q + ADDR_W'(beat_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    base_d      = base_q;
    beat_d      = beat_q;
    rr_last_d   = rr_last_q;
    grant_d     = '0;
    tag_push    = 1'b0;
    m_done      = '0;
    m_wdata_ack = '0;
    ddr_wr_en   = 1'b0;
    ddr_rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          id_d      = pick_id;
          base_d    = pick_id ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
          beat_d    = '0;
          rr_last_d = pick_id;
          grant_d   = id2mask(pick_id);
          tag_push  = ~m_wr[pick_id];
          state_d   = m_wr[pick_id] ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (!ddr_wr_busy) begin
          ddr_wr_en   = 1'b1;
          m_wdata_ack = id2mask(id_q);
          beat_d      = beat_q + 1'b1;
          if (beat_q == LAST) begin
            m_done  = id2mask(id_q);
            state_d = S_FINISH;
          end
        end
      end
      S_READ: begin
        if (!ddr_rd_busy) begin
          ddr_rd_en = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST) begin
            m_done  = id2mask(id_q);
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Returns are tracked independently of the FSM; an untagged return is flagged, not routed.
  always_comb begin
    m_rd_valid = '0;
    tag_pop    = 1'b0;
    ret_cnt_d  = ret_cnt_q;
    err_d      = err_q;
    if (ddr_rd_valid) begin
      if (tag_empty) begin
        err_d = 1'b1;
      end else begin
        m_rd_valid = id2mask(tag_head);
        ret_cnt_d  = ret_cnt_q + 1'b1;
        tag_pop    = (ret_cnt_q == LAST);
      end
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      base_q    <= '0;
      beat_q    <= '0;
      rr_last_q <= 1'b1;
      grant_q   <= '0;
      ret_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      ret_cnt_q <= ret_cnt_d;
      err_q     <= err_d;
    end
  end

  assign m_grant     = grant_q;
  assign err_o       = err_q;
  assign ddr_wr_addr = ddr_wr_en ? beat_addr : '0;
  assign ddr_rd_addr = ddr_rd_en ? beat_addr : '0;
  assign ddr_wr_data = ddr_wr_en ? (id_q ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0]) : '0;
  assign ddr_wr_mask = '0;
  assign m_rd_data   = ddr_rd_valid ? ddr_rd_data : '0;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed scenarios with randomized data/addresses/busy, checked against a transaction-level scoreboard.
module tb_ddr_burst_arbiter;

  localparam int BL = 32;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TD = 4;

  logic            ddr_clk = 1'b0;
  logic            ddr_rst_n;
  logic [1:0]      m_req, m_wr, m_grant, m_done, m_wdata_ack, m_rd_valid;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rd_data, ddr_wr_data, ddr_rd_data;
  logic            ddr_wr_busy, ddr_wr_en, ddr_rd_busy, ddr_rd_en, ddr_rd_valid, err_o;
  logic [AW-1:0]   ddr_wr_addr, ddr_rd_addr;
  logic [DW/8-1:0] ddr_wr_mask;

  always #5 ddr_clk = ~ddr_clk;

  ddr_burst_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_grant(m_grant), .m_done(m_done),
    .m_wdata(m_wdata), .m_wdata_ack(m_wdata_ack), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
    .ddr_wr_busy(ddr_wr_busy), .ddr_wr_en(ddr_wr_en), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data(ddr_wr_data), .ddr_wr_mask(ddr_wr_mask), .ddr_rd_busy(ddr_rd_busy),
    .ddr_rd_en(ddr_rd_en), .ddr_rd_addr(ddr_rd_addr), .ddr_rd_data(ddr_rd_data),
    .ddr_rd_valid(ddr_rd_valid), .err_o(err_o)
  );

  // Per-master show-ahead write FIFOs: random contents, head advanced by the DUT's ack.
  logic [DW-1:0] wmem [2][512];
  int            wcnt [2] = '{0, 0};
  assign m_wdata = {wmem[1][wcnt[1] & 511], wmem[0][wcnt[0] & 511]};
  always @(posedge ddr_clk)
    for (int i = 0; i < 2; i++) if (m_wdata_ack[i]) wcnt[i] <= wcnt[i] + 1;

  typedef struct { logic [0:0] id; logic wr; logic [AW-1:0] addr; } burst_t;
  burst_t exp_q[$];
  int     ret_q[$];
  burst_t cur;
  logic   active = 1'b0, exp_err = 1'b0;
  int     beat = 0, ret_cnt = 0, cyc = 0, first_cyc = 0, end_cyc = -1000, last_gap = 0;
  int     wexp [2] = '{0, 0};
  int     n_grant [2] = '{0, 0};
  int     n_rdv [2] = '{0, 0};
  int     errors = 0, checks = 0;
  int     mdl_last = 1;
  int     busy_mode = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every grant, beat and return is matched to the predicted burst sequence.
  always @(negedge ddr_clk) begin
    logic [AW-1:0] ea;
    logic          is_last;
    cyc++;
    if (!ddr_rst_n) begin
      active = 1'b0; exp_q.delete(); ret_q.delete(); ret_cnt = 0; exp_err = 1'b0;
    end else begin
      check("err_o", err_o, exp_err);
      if (m_grant != 2'b00) begin
        if (exp_q.size() == 0) check("grant_unexpected", m_grant, 0);
        else begin
          cur = exp_q.pop_front();
          check("grant_id", m_grant, 2'b01 << cur.id);
          active = 1'b1; beat = 0; n_grant[cur.id]++;
          if (!cur.wr) ret_q.push_back(int'(cur.id));
        end
      end
      check("wr_rd_exclusive", ddr_wr_en & ddr_rd_en, 0);
      if (ddr_wr_en || ddr_rd_en) begin
        check("beat_in_burst", {active, cur.wr}, {1'b1, ddr_wr_en});
        if (beat == 0) begin last_gap = cyc - end_cyc - 1; first_cyc = cyc; end
        ea = cur.addr + AW'(beat);
        if (ddr_wr_en) begin
          check("wr_addr", ddr_wr_addr, ea);
          check("wr_data", ddr_wr_data, wmem[cur.id][wexp[cur.id] & 511]);
          check("wr_ack", m_wdata_ack, 2'b01 << cur.id);
          wexp[cur.id]++;
        end else begin
          check("rd_addr", ddr_rd_addr, ea);
          check("rd_no_ack", m_wdata_ack, 0);
        end
        is_last = (beat == BL - 1);
        check("done", m_done, is_last ? (2'b01 << cur.id) : 2'b00);
        beat++;
        if (is_last) begin active = 1'b0; end_cyc = cyc; end
      end else begin
        check("idle_ack_done", {m_wdata_ack, m_done}, 0);
      end
      if (ddr_rd_valid) begin
        if (ret_q.size() == 0) begin
          check("rdv_untagged", m_rd_valid, 0);
          exp_err = 1'b1;
        end else begin
          check("rd_owner", m_rd_valid, 2'b01 << ret_q[0]);
          check("rd_data", m_rd_data, ddr_rd_data);
          n_rdv[ret_q[0]]++;
          ret_cnt++;
          if (ret_cnt == BL) begin void'(ret_q.pop_front()); ret_cnt = 0; end
        end
      end else begin
        check("rd_valid_idle", m_rd_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge ddr_clk); #1;
    m_req = m_req & ~m_grant;
    case (busy_mode)
      1: ddr_wr_busy = ~ddr_wr_busy;
      2: begin ddr_wr_busy = 1'($urandom_range(0, 1)); ddr_rd_busy = 1'($urandom_range(0, 1)); end
      default: begin ddr_wr_busy = 1'b0; ddr_rd_busy = 1'b0; end
    endcase
  endtask

  task automatic expect_burst(input int id, input logic wr, input logic [AW-1:0] addr);
    burst_t b;
    b.id = 1'(id); b.wr = wr; b.addr = addr;
    exp_q.push_back(b);
    mdl_last = id;
  endtask

  task automatic req(input int id, input logic wr, input logic [AW-1:0] addr);
    m_req[id] = 1'b1;
    m_wr[id] = wr;
    m_addr[id*AW +: AW] = addr;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || active) && n < 400) begin tick(); n++; end
    check({tag, "_timeout"}, n < 400, 1'b1);
    repeat (3) tick();
  endtask

  task automatic ret_beats(input int n);
    int sent = 0;
    while (sent < n) begin
      ddr_rd_valid = ($urandom_range(0, 3) != 0);
      ddr_rd_data  = {$urandom, $urandom, $urandom, $urandom};
      if (ddr_rd_valid) sent++;
      tick();
    end
    ddr_rd_valid = 1'b0;
    ddr_rd_data  = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, g0, rv0, rv1;
    logic [AW-1:0] a0, a1, a5;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 512; j++) wmem[i][j] = {$urandom, $urandom, $urandom, $urandom};
    ddr_rst_n = 1'b0; m_req = '0; m_wr = '0; m_addr = '0;
    ddr_wr_busy = 1'b0; ddr_rd_busy = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;
    repeat (3) @(posedge ddr_clk);
    #1;
    check("rst_ctrl", {m_grant, m_done, m_wdata_ack, m_rd_valid, ddr_wr_en, ddr_rd_en, err_o}, 0);
    check("rst_addr", {ddr_wr_addr, ddr_rd_addr}, 0);
    check("rst_data", ddr_wr_data | m_rd_data, 0);
    check("rst_mask", ddr_wr_mask, 0);
    ddr_rst_n = 1'b1;
    mdl_last = 1;
    repeat (2) tick();

    // Two ties in a row: master 0 wins both because master 1 was last served each time.
    for (int k = 0; k < 2; k++) begin
      a0 = $urandom; a1 = $urandom;
      w = (mdl_last == 1) ? 0 : 1;
      expect_burst(w, 1'b1, w == 0 ? a0 : a1);
      expect_burst(1 - w, 1'b1, w == 0 ? a1 : a0);
      req(0, 1'b1, a0); req(1, 1'b1, a1);
      wait_idle("tie");
      check("tie_gap_cycles", last_gap, 2);
    end

    // Single write at 0x100: grant exactly one cycle after the request, 32 contiguous beats.
    expect_burst(0, 1'b1, 32'h100);
    req(0, 1'b1, 32'h100);
    tick();
    check("grant_latency", m_grant, 2'b01);
    wait_idle("m0_wr");
    check("wr_span_nobusy", end_cyc - first_cyc, BL - 1);

    // Alternating write busy with an address that wraps past 2^32.
    busy_mode = 1;
    expect_burst(1, 1'b1, 32'hFFFF_FFF0);
    req(1, 1'b1, 32'hFFFF_FFF0);
    wait_idle("busy_wr");
    check("wr_span_busy", end_cyc - first_cyc, 2 * (BL - 1));
    busy_mode = 2;

    // Two reads from different masters, returns routed in issue order.
    rv0 = n_rdv[0]; rv1 = n_rdv[1];
    expect_burst(1, 1'b0, 32'h40); req(1, 1'b0, 32'h40); wait_idle("rd_m1");
    expect_burst(0, 1'b0, 32'h80); req(0, 1'b0, 32'h80); wait_idle("rd_m0");
    ret_beats(2 * BL);
    repeat (2) tick();
    check("rd_beats_m1", n_rdv[1] - rv1, BL);
    check("rd_beats_m0", n_rdv[0] - rv0, BL);

    // Fill the tag FIFO, hold a fifth read, let a write through, then release via one return.
    rv0 = n_rdv[0]; rv1 = n_rdv[1];
    for (int k = 0; k < TD; k++) begin
      a0 = $urandom;
      expect_burst(k % 2, 1'b0, a0); req(k % 2, 1'b0, a0); wait_idle("rd_fill");
    end
    g0 = n_grant[0];
    a5 = $urandom;
    req(0, 1'b0, a5);
    repeat (20) tick();
    check("rd5_held", n_grant[0], g0);
    a1 = $urandom;
    expect_burst(1, 1'b1, a1); req(1, 1'b1, a1); wait_idle("wr_while_full");
    check("rd5_still_held", n_grant[0], g0);
    expect_burst(0, 1'b0, a5);
    ret_beats(BL);
    wait_idle("rd5");
    check("rd5_granted", n_grant[0], g0 + 1);
    ret_beats(TD * BL);
    repeat (2) tick();
    check("drain_beats_m0", n_rdv[0] - rv0, 3 * BL);
    check("drain_beats_m1", n_rdv[1] - rv1, 2 * BL);
    busy_mode = 0;
    repeat (2) tick();

    // Return with nothing outstanding sets a sticky error.
    check("err_before", err_o, 1'b0);
    ddr_rd_valid = 1'b1; ddr_rd_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    ddr_rd_valid = 1'b0; ddr_rd_data = '0;
    tick();
    check("err_set", err_o, 1'b1);
    repeat (5) tick();
    check("err_sticky", err_o, 1'b1);

    // Asynchronous reset in the middle of a write burst.
    a0 = $urandom;
    expect_burst(0, 1'b1, a0); req(0, 1'b1, a0);
    repeat (12) tick();
    check("mid_burst_active", ddr_wr_en, 1'b1);
    #2 ddr_rst_n = 1'b0;
    #1;
    check("arst_ctrl", {m_grant, m_done, m_wdata_ack, ddr_wr_en, ddr_rd_en, err_o}, 0);
    check("arst_addr_data", {ddr_wr_addr, ddr_wr_data}, 0);
    @(posedge ddr_clk); #1;
    ddr_rst_n = 1'b1;
    mdl_last = 1;
    tick();
    a1 = $urandom;
    expect_burst(1, 1'b1, a1); req(1, 1'b1, a1);
    wait_idle("post_reset_wr");
    check("post_reset_err", err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
